// File: rtl/hilo_mul_sequencer.sv
// hilo_mul_sequencer: multi-cycle HI/LO multiply sequencer for the EX stage.
// Iterative shift-add multiply retiring BITS_PER_CYCLE multiplier bits per cycle.
// Optional divide support (div/divu, restoring) when HILO_DIV_EN is defined.
module hilo_mul_sequencer #(
  parameter  int BITS_PER_CYCLE = 1,
  localparam int ITERS          = 32 / BITS_PER_CYCLE
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [5:0]  ALUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Abort,
  output logic        Stall,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] Result,
  output logic        ResultValid
);

  localparam logic [5:0] OP_MUL   = 6'b000011;
  localparam logic [5:0] OP_MULT  = 6'b000100;
  localparam logic [5:0] OP_MULTU = 6'b000101;
  localparam logic [5:0] OP_MADD  = 6'b000110;
  localparam logic [5:0] OP_MSUB  = 6'b000111;
  localparam logic [5:0] OP_MTHI  = 6'b010110;
  localparam logic [5:0] OP_MTLO  = 6'b010111;
  localparam logic [5:0] OP_MFHI  = 6'b011000;
  localparam logic [5:0] OP_MFLO  = 6'b011001;
`ifdef HILO_DIV_EN
  localparam logic [5:0] OP_DIV   = 6'b011101;
  localparam logic [5:0] OP_DIVU  = 6'b011110;
`endif

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [5:0]  op_q, op_d;
  logic        neg_q, neg_d;        // final product/quotient is negative
  logic [63:0] acc_q, acc_d;        // product accumulator / {rem, dividend}
  logic [63:0] mcand_q, mcand_d;    // multiplicand, pre-shifted each iteration
  logic [31:0] mplier_q, mplier_d;  // multiplier (consumed LSB first) / divisor
  logic [31:0] hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic        rv_q, rv_d;
`ifdef HILO_DIV_EN
  logic        rneg_q, rneg_d;      // remainder follows the dividend sign
  logic [31:0] a_q, a_d;            // raw dividend for the divide-by-zero case
  logic [32:0] rem_t;
  logic [31:0] quo_t, quo_f, rem_f;
  logic        is_div;
`endif

  logic        is_mulcls, is_moveto, is_movefrom, is_mul, is_signed;
  logic [63:0] prod;

  // Magnitude of a possibly-signed operand; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude (the 33-bit result fits in 32).
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  assign is_mul      = (ALUOp == OP_MUL);
  assign is_mulcls   = is_mul || (ALUOp == OP_MULT) || (ALUOp == OP_MULTU) ||
                       (ALUOp == OP_MADD) || (ALUOp == OP_MSUB);
  assign is_moveto   = (ALUOp == OP_MTHI) || (ALUOp == OP_MTLO);
  assign is_movefrom = (ALUOp == OP_MFHI) || (ALUOp == OP_MFLO);
`ifdef HILO_DIV_EN
  assign is_div      = (ALUOp == OP_DIV) || (ALUOp == OP_DIVU);
  assign is_signed   = (ALUOp != OP_MULTU) && (ALUOp != OP_DIVU);
`else
  assign is_signed   = (ALUOp != OP_MULTU);
`endif

  assign Busy        = (state_q != IDLE);
  assign Hi          = hi_q;
  assign Lo          = lo_q;
  assign Result      = result_q;
  assign ResultValid = rv_q;
  assign prod        = neg_q ? (~acc_q + 64'd1) : acc_q;

  // Hold HI/LO users while busy; hold a mul in EX until its result strobe,
  // at which point it is released and must not be re-accepted.
`ifdef HILO_DIV_EN
  assign Stall = Start && ((Busy && (is_mulcls || is_moveto || is_movefrom || is_div)) ||
                           (is_mul && !rv_q));
`else
  assign Stall = Start && ((Busy && (is_mulcls || is_moveto || is_movefrom)) ||
                           (is_mul && !rv_q));
`endif

  // Next-state: accept/iterate/finish; Abort overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    rv_d     = 1'b0;
`ifdef HILO_DIV_EN
    rneg_d   = rneg_q;
    a_d      = a_q;
    rem_t    = {1'b0, acc_q[63:32]};
    quo_t    = acc_q[31:0];
    quo_f    = neg_q  ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
    rem_f    = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
`endif
    if (Abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start && is_mulcls && !(is_mul && rv_q)) begin
            state_d  = ITER;
            cnt_d    = 5'd0;
            op_d     = ALUOp;
            neg_d    = is_signed && (A[31] ^ B[31]);
            acc_d    = 64'd0;
            mcand_d  = {32'd0, mag(A, is_signed)};
            mplier_d = mag(B, is_signed);
`ifdef HILO_DIV_EN
          end else if (Start && is_div) begin
            state_d  = ITER;
            cnt_d    = 5'd0;
            op_d     = ALUOp;
            neg_d    = is_signed && (A[31] ^ B[31]);
            rneg_d   = is_signed && A[31];
            a_d      = A;
            acc_d    = {32'd0, mag(A, is_signed)};
            mplier_d = mag(B, is_signed);
`endif
          end else if (Start && (ALUOp == OP_MTHI)) begin
            hi_d = A;
          end else if (Start && (ALUOp == OP_MTLO)) begin
            lo_d = A;
          end
        end
        ITER: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ITERS - 1)) state_d = FIN;
`ifdef HILO_DIV_EN
          if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            for (int k = 0; k < BITS_PER_CYCLE; k++) begin
              rem_t = {rem_t[31:0], quo_t[31]};
              quo_t = {quo_t[30:0], 1'b0};
              if (rem_t >= {1'b0, mplier_q}) begin
                rem_t    = rem_t - {1'b0, mplier_q};
                quo_t[0] = 1'b1;
              end
            end
            acc_d = {rem_t[31:0], quo_t};
          end else
`endif
          begin
            acc_d    = acc_q + mcand_q * 64'(mplier_q[BITS_PER_CYCLE-1:0]);
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
          end
        end
        FIN: begin
          state_d = IDLE;
          unique case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
            OP_MADD:           {hi_d, lo_d} = {hi_q, lo_q} + prod;
            OP_MSUB:           {hi_d, lo_d} = {hi_q, lo_q} - prod;
            OP_MUL: begin
              result_d = prod[31:0];
              rv_d     = 1'b1;
            end
`ifdef HILO_DIV_EN
            OP_DIV, OP_DIVU: begin
              if (mplier_q == 32'd0) begin
                hi_d = a_q;
                lo_d = 32'hFFFF_FFFF;
              end else begin
                hi_d = rem_f;
                lo_d = quo_f;
              end
            end
`endif
            default: ;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 6'd0;
      neg_q    <= 1'b0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      result_q <= 32'd0;
      rv_q     <= 1'b0;
`ifdef HILO_DIV_EN
      rneg_q   <= 1'b0;
      a_q      <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      rv_q     <= rv_d;
`ifdef HILO_DIV_EN
      rneg_q   <= rneg_d;
      a_q      <= a_d;
`endif
    end
  end

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// Directed-vector bench for hilo_mul_sequencer (default build, BITS_PER_CYCLE=1).
module tb_hilo_mul_sequencer;

  logic        Clk = 1'b0, Rst = 1'b1, Start = 1'b0, Abort = 1'b0;
  logic [5:0]  ALUOp = 6'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic        Stall, Busy, ResultValid;
  logic [31:0] Hi, Lo, Result;

  int checks = 0, failures = 0;
  int n, ns;

  localparam logic [5:0] MUL = 6'b000011, MULT = 6'b000100, MULTU = 6'b000101,
                         MADD = 6'b000110, MSUB = 6'b000111, MTHI = 6'b010110,
                         MTLO = 6'b010111, MFHI = 6'b011000;

  hilo_mul_sequencer dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .ALUOp(ALUOp), .A(A), .B(B),
    .Abort(Abort), .Stall(Stall), .Busy(Busy), .Hi(Hi), .Lo(Lo),
    .Result(Result), .ResultValid(ResultValid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // Present one instruction for exactly one accept edge.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; ALUOp = op; A = a; B = b;
    tick();
    Start = 1'b0;
  endtask

  // Count cycles until Busy drops (bounded); Stall tallied while Busy.
  task automatic wait_idle(output int cyc, output int stl);
    cyc = 0; stl = 0;
    #1;
    while (Busy && cyc < 200) begin
      if (Stall) stl++;
      @(posedge Clk); #2;
      cyc++;
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    Rst = 1'b0;
    #1;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_hilo", {Hi, Lo}, 64'd0);
    chk("rst_result", {32'd0, Result}, 64'd0);
    chk("rst_rv", 64'(ResultValid), 64'd0);

    // mult -2 x 3: Busy for 33 cycles
    tick();
    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n, ns);
    chk("mult_busy_cycles", 64'(n), 64'd33);
    chk("mult_hilo", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // multu all-ones squared
    tick();
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n, ns);
    chk("multu_hilo", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);

    // Reset mid-ITER: nothing written, then or later
    tick();
    issue(MULT, 32'd5, 32'd6);
    repeat (5) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rstmid_busy", 64'(Busy), 64'd0);
    chk("rstmid_hilo", {Hi, Lo}, 64'd0);
    repeat (40) tick();
    chk("rstmid_late_hilo", {Hi, Lo}, 64'd0);

    // mthi 0, mtlo 10, madd 4*5 with msub 2*3 held behind it
    issue(MTHI, 32'd0, 32'd0);
    issue(MTLO, 32'd10, 32'd0);
    chk("mtlo_hilo", {Hi, Lo}, 64'd10);
    issue(MADD, 32'd4, 32'd5);
    Start = 1'b1; ALUOp = MSUB; A = 32'd2; B = 32'd3;
    wait_idle(n, ns);
    chk("madd_stall_cycles", 64'(ns), 64'd33);
    chk("madd_hilo", {Hi, Lo}, 64'd30);
    chk("msub_nostall_idle", 64'(Stall), 64'd0);
    tick();
    Start = 1'b0;
    wait_idle(n, ns);
    chk("msub_hilo", {Hi, Lo}, 64'd24);

    // mul 7 * -6: Stall from accept until the ResultValid cycle
    tick();
    Start = 1'b1; ALUOp = MUL; A = 32'd7; B = 32'hFFFF_FFFA;
    n = 0; ns = 0;
    #1;
    while (!ResultValid && n < 200) begin
      if (Stall) ns++;
      @(posedge Clk); #2;
      n++;
    end
    chk("mul_stall_cycles", 64'(ns), 64'd34);
    chk("mul_result", {32'd0, Result}, 64'hFFFF_FFD6);
    chk("mul_stall_released", 64'(Stall), 64'd0);
    chk("mul_hilo_kept", {Hi, Lo}, 64'd24);
    tick();
    Start = 1'b0;
    chk("mul_no_reaccept", 64'(Busy), 64'd0);
    chk("mul_rv_pulse", 64'(ResultValid), 64'd0);

    // mfhi held while a mult runs (signed 0x80000000 corner)
    issue(MULT, 32'h8000_0000, 32'h8000_0000);
    Start = 1'b1; ALUOp = MFHI;
    wait_idle(n, ns);
    chk("mfhi_stall_cycles", 64'(ns), 64'd33);
    chk("mfhi_stall_idle", 64'(Stall), 64'd0);
    chk("minint_hilo", {Hi, Lo}, 64'h4000_0000_0000_0000);
    tick();
    Start = 1'b0;

    // Abort at ITER cycle 10
    issue(MULT, 32'd3, 32'd3);
    repeat (10) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    repeat (40) tick();
    chk("abort_hilo", {Hi, Lo}, 64'h4000_0000_0000_0000);

    // Abort beats Start in IDLE
    Abort = 1'b1;
    issue(MTLO, 32'd5, 32'd0);
    Abort = 1'b0;
    chk("abort_mtlo", {32'd0, Lo}, 64'd0);

    // Unknown code is ignored
    issue(6'b111111, 32'd1, 32'd1);
    chk("unknown_busy", 64'(Busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
